// File: rtl/mm_sequencer.sv
// Matrix-multiply pass sequencer: loads DIM rows of A, runs the systolic
// compute window, then streams DIM result rows out under backpressure.
module mm_sequencer #(
  parameter int DIM     = 8,
  parameter int CMP_CYC = 3*DIM-2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   a_valid,
  output logic                   a_ready,
  output logic                   wr_en,
  output logic [$clog2(DIM)-1:0] wr_row,
  output logic                   mem_en,
  output logic                   clr_acc,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(CMP_CYC+1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);
  localparam logic [CW-1:0] CMP_LAST = CW'(CMP_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_READ, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] cmp_q, cmp_d;
  logic [RW-1:0] rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cmp_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cmp_q   <= cmp_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cmp_d   = cmp_q;
    rd_d    = rd_q;
    a_ready = 1'b0;
    wr_en   = 1'b0;
    wr_row  = '0;
    mem_en  = 1'b0;
    clr_acc = 1'b0;
    c_row   = '0;
    c_valid = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
        end
      end
      S_LOAD: begin
        a_ready = 1'b1;
        wr_en   = a_valid;
        wr_row  = row_q;
        if (a_valid) begin
          if (row_q == ROW_LAST) begin
            state_d = S_COMPUTE;
            row_d   = '0;
            cmp_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_COMPUTE: begin
        mem_en  = 1'b1;
        clr_acc = (cmp_q == '0);
        if (cmp_q == CMP_LAST) begin
          state_d = S_READ;
          cmp_d   = '0;
          rd_d    = '0;
        end else begin
          cmp_d = cmp_q + CW'(1);
        end
      end
      S_READ: begin
        c_valid = 1'b1;
        c_row   = rd_q;
        if (c_ready) begin
          if (rd_q == ROW_LAST) begin
            state_d = S_DONE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort squashes every side effect of the current cycle
    if (abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      cmp_d   = '0;
      rd_d    = '0;
      a_ready = 1'b0;
      wr_en   = 1'b0;
      mem_en  = 1'b0;
      clr_acc = 1'b0;
      c_valid = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// Randomized bench for mm_sequencer: each pass is checked cycle by cycle
// against an expected timeline built from the pass-level rules.
module tb_mm_sequencer;

  localparam int DIM = 8;
  localparam int CMP = 3*DIM-2;
  localparam int RW  = $clog2(DIM);
  localparam int N   = 256;

  typedef struct packed {
    logic          ar;
    logic          wr;
    logic [RW-1:0] wrow;
    logic          mem;
    logic          clr;
    logic          cv;
    logic [RW-1:0] crow;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, a_valid, c_ready;
  logic          a_ready, wr_en, mem_en, clr_acc, c_valid, busy, done;
  logic [RW-1:0] wr_row, c_row;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mm_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .mem_en  (mem_en),
    .clr_acc (clr_acc),
    .c_row   (c_row),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o.ar   = a_ready;
    o.wr   = wr_en;
    o.wrow = wr_row;
    o.mem  = mem_en;
    o.clr  = clr_acc;
    o.cv   = c_valid;
    o.crow = c_row;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    cyc();
    start   = 1'b1;
    abort   = 1'b0;
    a_valid = 1'b0;
    c_ready = 1'b0;
    #1;
    chk("idle", 32'(get_obs()), 32'd0);
  endtask

  // avp/crp: percent chance of a_valid/c_ready; bp plants a 5-cycle stall at row 3
  task automatic run_pass(input int avp, input int crp,
                          input bit rnd_start, input bit bp);
    bit   av[N];
    bit   cr[N];
    obs_t ex[N];
    int   t, loaded, k, last;
    for (int i = 0; i < N; i++) begin
      av[i] = (i >= 60) || ($urandom_range(99) < avp);
      cr[i] = (i >= 150) || ($urandom_range(99) < crp);
      ex[i] = '0;
    end
    t = 0;
    loaded = 0;
    while (loaded < DIM) begin
      ex[t].busy = 1'b1;
      ex[t].ar   = 1'b1;
      ex[t].wr   = av[t];
      ex[t].wrow = RW'(loaded);
      if (av[t]) loaded++;
      t++;
    end
    for (int i = 0; i < CMP; i++) begin
      ex[t].busy = 1'b1;
      ex[t].mem  = 1'b1;
      ex[t].clr  = (i == 0);
      t++;
    end
    if (bp) begin
      for (int i = 0; i < 3; i++) cr[t+i] = 1'b1;
      for (int i = 3; i < 8; i++) cr[t+i] = 1'b0;
    end
    k = 0;
    while (k < DIM) begin
      ex[t].busy = 1'b1;
      ex[t].cv   = 1'b1;
      ex[t].crow = RW'(k);
      if (cr[t]) k++;
      t++;
    end
    ex[t].busy = 1'b1;
    ex[t].done = 1'b1;
    last = t + 1;
    launch();
    for (int i = 0; i <= last; i++) begin
      cyc();
      a_valid = av[i];
      c_ready = cr[i];
      start   = (rnd_start && i < last) ? 1'($urandom_range(1)) : 1'b0;
      #1;
      chk(bp ? "pass_bp" : "pass", 32'(get_obs()), 32'(ex[i]));
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    a_valid = 1'b0;
    c_ready = 1'b0;
    #1;
    chk("reset", 32'(get_obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_pass(100, 100, 1'b0, 1'b0);
    run_pass(50, 100, 1'b0, 1'b0);
    run_pass(100, 100, 1'b0, 1'b1);
    run_pass(60, 60, 1'b1, 1'b0);

    // abort at cmp_cnt=10, then a clean pass
    launch();
    for (int i = 0; i < 19; i++) begin
      cyc();
      start   = 1'b0;
      a_valid = 1'b1;
      c_ready = 1'b1;
      abort   = (i == 18);
      #1;
      if (i == 17) chk("pre_abort_mem", 32'(mem_en), 32'd1);
      if (i == 18) begin
        chk("abort_mem", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      abort = 1'b0;
      #1;
      chk("post_abort", 32'(get_obs()), 32'd0);
    end
    run_pass(100, 100, 1'b0, 1'b0);

    // start with abort in IDLE stays idle
    cyc();
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("start_abort", 32'(get_obs()), 32'd0);

    // async reset mid-compute
    launch();
    for (int i = 0; i < 12; i++) begin
      cyc();
      start   = 1'b0;
      a_valid = 1'b1;
    end
    #1;
    chk("pre_rst_mem", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(get_obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b0;

    for (int p = 0; p < 6; p++)
      run_pass($urandom_range(100, 30), $urandom_range(100, 30),
               1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
